// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: default operand
// width, FSM state encoding and a small state-decode helper.
package seq_divider_pkg;

    localparam int unsigned DIV_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    // States in which an operation is in flight and new requests are refused
    function automatic logic is_busy_state(input div_state_e st);
        return (st == ST_CALC) || (st == ST_FIX);
    endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One restoring shift-subtract iteration, purely combinational.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             dividend_bit,
    output logic [WIDTH-1:0] next_rem_c,
    output logic             q_bit_c
);

    logic [WIDTH:0] shifted_c;
    logic [WIDTH:0] trial_c;

    // Shift in the next dividend bit, trial-subtract, keep or restore.
    // The partial remainder stays below the divisor, so the WIDTH+1 bit
    // difference never overflows and its MSB is the sign.
    always_comb begin
        shifted_c  = {rem, dividend_bit};
        trial_c    = shifted_c - {1'b0, divisor};
        q_bit_c    = ~trial_c[WIDTH];
        next_rem_c = q_bit_c ? trial_c[WIDTH-1:0] : shifted_c[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider (MIPS DIVU, and DIV when SEQ_DIVIDER_SIGNED_EN
// is defined). One quotient bit per cycle through a single div_step instance;
// a FIX state applies sign correction so latency is identical in both builds.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
    input  logic             i_signed,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_dbz
);

    localparam int unsigned      CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_e       state_q;
    div_state_e       state_d;

    logic             accept_c;
    logic             div_zero_c;
    logic [WIDTH-1:0] dvd_mag_c;
    logic [WIDTH-1:0] dvs_mag_c;

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] step_rem_c;
    logic             step_qbit_c;

    logic [WIDTH-1:0] fix_quo_c;
    logic [WIDTH-1:0] fix_rem_c;

    logic             busy_d;
    logic             done_d;
    logic [WIDTH-1:0] quotient_d;
    logic [WIDTH-1:0] remainder_d;
    logic             dbz_d;

    // A request is taken only when idle or in the completion cycle
    assign accept_c   = i_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign div_zero_c = (i_divisor == '0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic dvd_neg_c;
    logic dvs_neg_c;
    logic quo_neg_q;
    logic rem_neg_q;

    // Signed requests divide magnitudes; signs are re-applied in FIX
    assign dvd_neg_c = i_signed & i_dividend[WIDTH-1];
    assign dvs_neg_c = i_signed & i_divisor[WIDTH-1];
    assign dvd_mag_c = dvd_neg_c ? (WIDTH'(0) - i_dividend) : i_dividend;
    assign dvs_mag_c = dvs_neg_c ? (WIDTH'(0) - i_divisor)  : i_divisor;

    // Quotient negative when operand signs differ; remainder follows dividend
    assign fix_quo_c = quo_neg_q ? (WIDTH'(0) - quo_q) : quo_q;
    assign fix_rem_c = rem_neg_q ? (WIDTH'(0) - rem_q) : rem_q;

    // Sign flags captured with the operands
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else if (accept_c) begin
            quo_neg_q <= dvd_neg_c ^ dvs_neg_c;
            rem_neg_q <= dvd_neg_c;
        end
    end
`else
    // Unsigned only: operands used as-is, FIX passes results through
    assign dvd_mag_c = i_dividend;
    assign dvs_mag_c = i_divisor;
    assign fix_quo_c = quo_q;
    assign fix_rem_c = rem_q;
`endif

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem          (rem_q),
        .divisor      (dvs_q),
        .dividend_bit (quo_q[WIDTH-1]),
        .next_rem_c   (step_rem_c),
        .q_bit_c      (step_qbit_c)
    );

    // Iteration datapath: quo_q shifts dividend bits out and quotient bits in
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (accept_c) begin
            rem_q <= '0;
            quo_q <= dvd_mag_c;
            dvs_q <= dvs_mag_c;
            cnt_q <= '0;
        end else if (state_q == ST_CALC) begin
            rem_q <= step_rem_c;
            quo_q <= {quo_q[WIDTH-2:0], step_qbit_c};
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = div_zero_c ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (cnt_q == LAST_STEP) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (accept_c) begin
                    state_d = div_zero_c ? ST_DONE : ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM output logic: next values of the registered outputs
    always_comb begin
        busy_d      = is_busy_state(state_d);
        done_d      = (state_d == ST_DONE);
        quotient_d  = o_quotient;
        remainder_d = o_remainder;
        dbz_d       = o_dbz;
        if (accept_c && div_zero_c) begin
            quotient_d  = '1;
            remainder_d = i_dividend;
            dbz_d       = 1'b1;
        end else if (state_q == ST_FIX) begin
            quotient_d  = fix_quo_c;
            remainder_d = fix_rem_c;
            dbz_d       = 1'b0;
        end
    end

    // Output registers; results change only when DONE is entered
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_quotient  <= '0;
            o_remainder <= '0;
            o_dbz       <= 1'b0;
        end else begin
            o_busy      <= busy_d;
            o_done      <= done_d;
            o_quotient  <= quotient_d;
            o_remainder <= remainder_d;
            o_dbz       <= dbz_d;
        end
    end

endmodule
